// File: rtl/addend_recover.sv
// Bit-serial recovery of the unknown addend b from an adder result: b = s - a - cin.
// One full-subtractor bit per clock, LSB first, with a single borrow flip-flop.
module addend_recover #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] b,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int            CW   = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           borrow;
    logic [WIDTH:0] s_sr;
    logic [WIDTH:0] a_sr;
    logic [WIDTH:0] result;

    logic           s_bit;
    logic           a_bit;
    logic           diff;
    logic           borrow_next;
    logic [WIDTH:0] result_next;

    always_comb begin
        s_bit       = s_sr[0];
        a_bit       = a_sr[0];
        diff        = s_bit ^ a_bit ^ borrow;
        borrow_next = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & borrow);
        // Each new difference bit enters at the top, so bit 0 lands in position 0 after WIDTH+1 shifts.
        result_next = {diff, result[WIDTH:1]};
    end

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            s_sr   <= '0;
            a_sr   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            b      <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        s_sr   <= s;
                        a_sr   <= {1'b0, a};
                        borrow <= cin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    s_sr   <= s_sr >> 1;
                    a_sr   <= a_sr >> 1;
                    borrow <= borrow_next;
                    result <= result_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        b     <= result_next[WIDTH-1:0];
                        // Out of range if the WIDTH+1-bit difference overflows WIDTH bits or went negative.
                        err   <= result_next[WIDTH] | borrow_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/addend_recover.md
ADDEND_RECOVER -- requirements
Module: addend_recover

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand width in bits (legal 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a recovery; sampled only in IDLE.
REQ-005 The block SHALL have port s, input, WIDTH+1 bits: the adder result, with the carry-out as MSB.
REQ-006 The block SHALL have port a, input, WIDTH bits: the known addend.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in used by the original add.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a recovery is running.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port b, output, WIDTH bits: the recovered addend, b = s - a - cin.
REQ-011 The block SHALL have port err, output, 1 bit: high when the true value of s - a - cin is outside 0..2^WIDTH-1.

Function
REQ-012 The block SHALL be a bit-serial full subtractor, LSB first, one bit per clock, using a single borrow flip-flop.
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE SHALL go to RUN on the edge where start=1.
- That same edge loads s, a (zero-extended to WIDTH+1) and cin into internal shift registers.
- It sets the borrow flip-flop to cin and clears the bit counter to 0.
REQ-015 In RUN, each edge SHALL process bit i = counter:
- diff = s_i ^ a_i ^ borrow
- borrow_next = (~s_i & a_i) | (~(s_i ^ a_i) & borrow)
- diff shifts into the result register MSB-first (so bit 0 ends in position 0); the counter increments.
REQ-016 RUN SHALL last exactly WIDTH+1 edges (bits 0..WIDTH), and the edge processing bit WIDTH SHALL go to DONE.
REQ-017 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-018 done SHALL be 1 only in DONE, so it rises WIDTH+1 cycles after the start edge.
REQ-019 busy SHALL be 1 exactly in RUN; it is 0 in IDLE and DONE.
REQ-020 At the transition into DONE, b SHALL be loaded with result bits WIDTH-1..0, and err SHALL be loaded with (result bit WIDTH) | (final borrow).
REQ-021 b and err SHALL hold their values through DONE and IDLE until the next RUN-to-DONE transition.
- They do not change during RUN.
REQ-022 start SHALL be ignored in RUN and DONE, and no request SHALL be queued.
- A start held high through DONE is accepted on the first IDLE edge.
REQ-023 s, a and cin SHALL be sampled only at the start edge, so input changes during RUN have no effect.
REQ-024 Back-to-back operation SHALL be supported: start high in the IDLE cycle right after DONE begins a new RUN, giving a minimum period of WIDTH+3 cycles.

Reset
REQ-025 With reset=1 at a rising edge, the block SHALL on that edge:
- enter IDLE
- clear the counter, borrow and shift registers
- drive busy=0, done=0, b=0 and err=0
REQ-026 Reset SHALL take priority over start and over every state, including mid-RUN.
- An aborted operation produces no done pulse.
REQ-027 Outputs SHALL be undefined before the first reset edge; after it, the block SHALL be fully deterministic.

Verification (WIDTH=8)
REQ-028 Nominal recovery: s=9'h0B4, a=8'h5A, cin=1, start pulsed.
- busy=1 for 9 cycles.
- done=1 in cycle 9 after the start edge, with b=8'h59 and err=0.
REQ-029 Maximum legal sum: s=9'h1FE, a=8'hFF, cin=0 -> b=8'hFF, err=0.
REQ-030 Underflow: s=9'h003, a=8'h05, cin=0 -> b=8'hFE, err=1.
- Also s=9'h1FF, a=8'h00, cin=0 -> b=8'hFF, err=1 (result bit 8 set).
REQ-031 Ignored start and input changes: start re-asserted and s/a changed during RUN.
- The result matches the originally sampled operands.
- Exactly one done pulse occurs.
- A start held through DONE starts a second run on the next cycle.
REQ-032 Reset mid-operation: reset asserted for 1 cycle on RUN bit 4.
- Next cycle: busy=0, done=0, b=0, err=0, and no done pulse follows.
- A subsequent start runs a full, correct 9-cycle operation.
